// File: rtl/divisor_punto_fijo.sv
// Signed fixed-point divider Y = X / Z in Q(magnitud).(precision) format.
// Restoring division on magnitudes, one quotient bit per clock, saturating result.
module divisor_punto_fijo #(
    parameter int ancho     = 20,
    parameter int signo     = 1,
    parameter int magnitud  = 5,
    parameter int precision = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [ancho-1:0] X,
    input  logic [ancho-1:0] Z,
    output logic [ancho-1:0] Y,
    output logic             valid,
    output logic             busy,
    output logic             sat,
    output logic             div_cero
);

    localparam int NW = ancho + precision;
    localparam int CW = $clog2(NW);

    localparam logic [NW-1:0]    LIM_POS = (NW'(1) << (ancho-1)) - NW'(1);
    localparam logic [NW-1:0]    LIM_NEG = NW'(1) << (ancho-1);
    localparam logic [ancho-1:0] Y_MAX   = {1'b0, {(ancho-1){1'b1}}};
    localparam logic [ancho-1:0] Y_MIN   = {1'b1, {(ancho-1){1'b0}}};

    if (ancho != signo + magnitud + precision) begin : g_chk_formato
        $error("divisor_punto_fijo: ancho must equal signo+magnitud+precision");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t;
    estado_t estado, estado_sig;

    logic             sign_q, x_cero, z_cero, x_neg;
    logic [ancho-1:0] az, rem;
    logic [NW-1:0]    num, quo;
    logic [CW-1:0]    cnt;

    logic [ancho-1:0] x_abs, z_abs;
    logic [ancho:0]   rem_sh, rem_dif;
    logic             q_bit;
    logic [ancho-1:0] y_fin;
    logic             sat_fin;

    // Magnitudes are unsigned, so the most negative input maps to 2^(ancho-1).
    assign x_abs   = X[ancho-1] ? (-X) : X;
    assign z_abs   = Z[ancho-1] ? (-Z) : Z;
    assign rem_sh  = {rem, num[NW-1]};
    assign rem_dif = rem_sh - {1'b0, az};
    assign q_bit   = (rem_sh >= {1'b0, az});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) estado <= IDLE;
        else          estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        y_fin      = '0;
        sat_fin    = 1'b0;
        case (estado)
            IDLE: if (start) estado_sig = (X == '0 || Z == '0) ? FIN : CALC;
            CALC: if (cnt == CW'(NW-1)) estado_sig = FIN;
            FIN:  estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
        // X==0 wins over Z==0: 0/0 yields a clean zero.
        if (x_cero) begin
            y_fin   = '0;
        end else if (z_cero) begin
            y_fin   = x_neg ? Y_MIN : Y_MAX;
            sat_fin = 1'b1;
        end else if (!sign_q) begin
            if (quo > LIM_POS) begin
                y_fin   = Y_MAX;
                sat_fin = 1'b1;
            end else begin
                y_fin   = quo[ancho-1:0];
            end
        end else begin
            if (quo > LIM_NEG) begin
                y_fin   = Y_MIN;
                sat_fin = 1'b1;
            end else begin
                y_fin   = -quo[ancho-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Y        <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            sat      <= 1'b0;
            div_cero <= 1'b0;
            sign_q   <= 1'b0;
            x_cero   <= 1'b0;
            z_cero   <= 1'b0;
            x_neg    <= 1'b0;
            az       <= '0;
            rem      <= '0;
            num      <= '0;
            quo      <= '0;
            cnt      <= '0;
        end else begin
            valid <= 1'b0;
            case (estado)
                IDLE: if (start) begin
                    sign_q <= X[ancho-1] ^ Z[ancho-1];
                    x_cero <= (X == '0);
                    z_cero <= (Z == '0);
                    x_neg  <= X[ancho-1];
                    az     <= z_abs;
                    num    <= {x_abs, {precision{1'b0}}};
                    rem    <= '0;
                    quo    <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                end
                CALC: begin
                    num <= num << 1;
                    rem <= q_bit ? rem_dif[ancho-1:0] : rem_sh[ancho-1:0];
                    quo <= {quo[NW-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                end
                FIN: begin
                    Y        <= y_fin;
                    sat      <= sat_fin;
                    div_cero <= ~x_cero & z_cero;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// Scoreboard bench for divisor_punto_fijo: directed vectors, handshake, reset abort, random.
module tb_divisor_punto_fijo;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [19:0] X = '0, Z = '0, Y;
    logic        valid, busy, sat, div_cero;

    divisor_punto_fijo dut (
        .clk(clk), .reset_n(reset_n), .start(start), .X(X), .Z(Z),
        .Y(Y), .valid(valid), .busy(busy), .sat(sat), .div_cero(div_cero)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] y;
        logic        s;
        logic        d;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    exp_t got;
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else begin
                got = sb.pop_front();
                chk("Y", 32'(Y), 32'(got.y));
                chk("sat", 32'(sat), 32'(got.s));
                chk("div_cero", 32'(div_cero), 32'(got.d));
                chk("latency", 32'(cyc - got.t0), 32'(got.lat));
            end
        end
    end

    // Called #1 after the accepting edge.
    task automatic push_exp(input logic [19:0] ey, input logic es, input logic ed, input int lat);
        exp_t e;
        e.y = ey; e.s = es; e.d = ed; e.t0 = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic send(input logic [19:0] x, input logic [19:0] z,
                        input logic [19:0] ey, input logic es, input logic ed);
        @(negedge clk);
        start = 1'b1; X = x; Z = z;
        @(posedge clk); #1;
        start = 1'b0;
        X = 20'($urandom); Z = 20'($urandom);
        push_exp(ey, es, ed, (x == '0 || z == '0) ? 1 : 35);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    function automatic logic [21:0] model(input logic [19:0] x, input logic [19:0] z);
        longint xs = longint'($signed(x));
        longint zs = longint'($signed(z));
        longint ax, az, q;
        logic [19:0] y;
        logic s, d;
        y = '0; s = 1'b0; d = 1'b0;
        if (xs == 0) begin
            y = '0;
        end else if (zs == 0) begin
            d = 1'b1; s = 1'b1;
            y = (xs < 0) ? 20'h80000 : 20'h7FFFF;
        end else begin
            ax = (xs < 0) ? -xs : xs;
            az = (zs < 0) ? -zs : zs;
            q  = (ax * 16384) / az;
            if ((xs < 0) != (zs < 0)) begin
                if (q > 524288) begin y = 20'h80000; s = 1'b1; end
                else y = 20'(-q);
            end else begin
                if (q > 524287) begin y = 20'h7FFFF; s = 1'b1; end
                else y = 20'(q);
            end
        end
        return {y, s, d};
    endfunction

    logic [19:0] tx [10] = '{20'hFC000, 20'h06000, 20'h80000, 20'h40000, 20'h80000,
                             20'h40000, 20'hF8000, 20'h00001, 20'h00000, 20'h00000};
    logic [19:0] tz [10] = '{20'h0C000, 20'hF8000, 20'h04000, 20'h01000, 20'hFC000,
                             20'hFF000, 20'h00000, 20'h00000, 20'h00000, 20'h0C000};
    logic [19:0] ty [10] = '{20'hFEAAB, 20'hFD000, 20'h80000, 20'h7FFFF, 20'h7FFFF,
                             20'h80000, 20'h80000, 20'h7FFFF, 20'h00000, 20'h00000};
    logic        ts [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        td [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [21:0] m;
        logic [19:0] rx, rz;
        #12;
        chk("rst_Y", 32'(Y), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_div_cero", 32'(div_cero), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1.0/3.0 with start pulses at E0+5 and E0+20 that must be ignored
        send(20'h04000, 20'h0C000, 20'h01555, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; X = 20'h40000; Z = 20'h01000;
        @(negedge clk); start = 1'b0;
        chk("busy_ignore", 32'(busy), 32'd1);
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send(tx[i], tz[i], ty[i], ts[i], td[i]);
            wait_done();
        end

        // start held through the valid cycle is taken on the next edge
        send(20'h04000, 20'h0C000, 20'h01555, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; X = 20'h06000; Z = 20'hF8000;
        for (int i = 0; i < 100 && !valid; i++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(20'hFD000, 1'b0, 1'b0, 35);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();

        // leave a non-zero, saturated result in place, then abort mid-division
        send(20'hF8000, 20'h00000, 20'h80000, 1'b1, 1'b1);
        wait_done();
        @(negedge clk);
        start = 1'b1; X = 20'h04000; Z = 20'h0C000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_Y", 32'(Y), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sat", 32'(sat), 32'd0);
        chk("abort_div_cero", 32'(div_cero), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        send(20'h06000, 20'hF8000, 20'hFD000, 1'b0, 1'b0);
        wait_done();

        for (int i = 0; i < 20; i++) begin
            rx = 20'($urandom);
            rz = 20'($urandom);
            if (i % 3 == 0) rz = rz >> 8;
            if (i % 4 == 1) rx = 20'($signed(rx) >>> 5);
            m = model(rx, rz);
            send(rx, rz, m[21:2], m[1], m[0]);
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
